stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear controller for the stopwatch timebase. It divides `CLK` into a one-second tick and sequences the external seconds and minutes counters with one-cycle count enables and a clear. It also provides a frozen "lap" view of the count to the display path. It sits between the debounced push-buttons and the two 0–59 counters.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 45 ++++
 rtl/stopwatch_ctrl.sv | 137 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/pause/lap/clear controller.
package stopwatch_pkg;

  localparam int unsigned SW_CNT_W         = 6;
  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;
  localparam int unsigned MAX_VAL_DEFAULT  = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  // One bit per push-button, used for both levels and detected edges
  typedef struct packed {
    logic clr;
    logic start;
    logic lap;
  } btn_evt_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK by TICK_DIV while enabled; emits a registered one-cycle tick after each wrap.
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Count holds while disabled so a paused partial second is preserved
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edges, run/pause/lap/clear FSM, carry and lap freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned MAX_VAL  = MAX_VAL_DEFAULT
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                start_stop_btn,
  input  logic                lap_btn,
  input  logic                clear_btn,
  input  logic [SW_CNT_W-1:0] sec_val,
  input  logic [SW_CNT_W-1:0] min_val,
  output logic                sec_en,
  output logic                min_en,
  output logic                cnt_clr,
  output logic [SW_CNT_W-1:0] disp_sec,
  output logic [SW_CNT_W-1:0] disp_min,
  output logic                running,
  output logic                lap_active
);

  sw_state_t           state_q, state_d;
  btn_evt_t            btn_q, btn_d;
  btn_evt_t            evt_q, evt_d;
  btn_evt_t            sel_c;
  logic                running_q, running_d;
  logic                lap_q, lap_d;
  logic                cnt_clr_q, cnt_clr_d;
  logic [SW_CNT_W-1:0] lap_sec_q, lap_sec_d;
  logic [SW_CNT_W-1:0] lap_min_q, lap_min_d;
  logic                pre_clr_c;
  logic                pre_rst_c;
  logic                tick;

  // Rising-edge detect; the edge is registered so the FSM sees a clean pulse
  always_comb begin
    btn_d.clr   = clear_btn;
    btn_d.start = start_stop_btn;
    btn_d.lap   = lap_btn;
    evt_d.clr   = btn_d.clr   & ~btn_q.clr;
    evt_d.start = btn_d.start & ~btn_q.start;
    evt_d.lap   = btn_d.lap   & ~btn_q.lap;
  end

  // Keep only the highest-priority edge: clear > start > lap
  always_comb begin
    sel_c = '0;
    if (evt_q.clr)        sel_c.clr   = 1'b1;
    else if (evt_q.start) sel_c.start = 1'b1;
    else if (evt_q.lap)   sel_c.lap   = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    pre_clr_c = 1'b0;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    unique case (state_q)
      IDLE: begin
        if (sel_c.clr)        cnt_clr_d = 1'b1;
        else if (sel_c.start) state_d   = RUN;
      end
      RUN: begin
        if (sel_c.start) begin
          state_d = PAUSE;
        end else if (sel_c.lap) begin
          state_d   = LAP;
          lap_sec_d = sec_val;
          lap_min_d = min_val;
        end
      end
      LAP: begin
        if (sel_c.start)    state_d = PAUSE;
        else if (sel_c.lap) state_d = RUN;
      end
      PAUSE: begin
        if (sel_c.clr) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
          pre_clr_c = 1'b1;
        end else if (sel_c.start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN) || (state_d == LAP);
    lap_d     = (state_d == LAP);
  end

  // Button history loads from live levels in reset so a held button makes no edge
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      btn_q     <= btn_d;
      evt_q     <= '0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      cnt_clr_q <= 1'b1;
      lap_sec_q <= '0;
      lap_min_q <= '0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_d;
      evt_q     <= evt_d;
      running_q <= running_d;
      lap_q     <= lap_d;
      cnt_clr_q <= cnt_clr_d;
      lap_sec_q <= lap_sec_d;
      lap_min_q <= lap_min_d;
    end
  end

  assign pre_rst_c = rst | pre_clr_c;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLK  (CLK),
    .rst  (pre_rst_c),
    .en   (running_q),
    .tick (tick)
  );

  // sec_val only moves on a tick, so it is stable while the registered tick is high
  assign sec_en     = tick;
  assign min_en     = tick & (sec_val == SW_CNT_W'(MAX_VAL));
  assign cnt_clr    = cnt_clr_q;
  assign running    = running_q;
  assign lap_active = lap_q;
  assign disp_sec   = lap_q ? lap_sec_q : sec_val;
  assign disp_min   = lap_q ? lap_min_q : min_val;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4 and a model of the external counters.
module tb_stopwatch_ctrl;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop_btn = 1'b0;
  logic       lap_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic [5:0] sec_val = '0;
  logic [5:0] min_val = '0;
  logic       sec_en, min_en, cnt_clr;
  logic [5:0] disp_sec, disp_min;
  logic       running, lap_active;

  logic       ld = 1'b0;
  logic [5:0] ld_sec = '0;
  logic [5:0] ld_min = '0;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int   cyc;
    logic s;
    logic m;
    logic c;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       run;
    logic       lap;
    logic [5:0] ds;
    logic [5:0] dm;
  } pr_t;

  ev_t evq[$];
  pr_t prq[$];

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .MAX_VAL  (59)
  ) dut (
    .CLK            (CLK),
    .rst            (rst),
    .start_stop_btn (start_stop_btn),
    .lap_btn        (lap_btn),
    .clear_btn      (clear_btn),
    .sec_val        (sec_val),
    .min_val        (min_val),
    .sec_en         (sec_en),
    .min_en         (min_en),
    .cnt_clr        (cnt_clr),
    .disp_sec       (disp_sec),
    .disp_min       (disp_min),
    .running        (running),
    .lap_active     (lap_active)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // External 0..59 seconds/minutes counters
  always @(posedge CLK) begin
    if (ld) begin
      sec_val <= ld_sec;
      min_val <= ld_min;
    end else if (cnt_clr) begin
      sec_val <= '0;
      min_val <= '0;
    end else begin
      if (sec_en) sec_val <= (sec_val == 6'd59) ? 6'd0 : sec_val + 6'd1;
      if (min_en) min_val <= (min_val == 6'd59) ? 6'd0 : min_val + 6'd1;
    end
  end

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic exp_tick(input int c, input logic m);
    evq.push_back('{c, 1'b1, m, 1'b0});
  endtask

  task automatic exp_clr(input int c);
    evq.push_back('{c, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic probe(input int c, input logic r, input logic l, input int ds, input int dm);
    prq.push_back('{c, r, l, 6'(ds), 6'(dm)});
  endtask

  // Monitor: any enable/clear pulse pops the event queue; probes fire on their cycle
  always @(negedge CLK) begin
    ev_t e;
    pr_t p;
    if (sec_en || min_en || cnt_clr) begin
      n_total++;
      if (evq.size() == 0) begin
        $display("FAIL pulse cyc=%0d got sec_en=%b min_en=%b cnt_clr=%b, required no pulse",
                 cyc, sec_en, min_en, cnt_clr);
      end else begin
        e = evq.pop_front();
        if (e.cyc == cyc && e.s == sec_en && e.m == min_en && e.c == cnt_clr)
          n_pass++;
        else
          $display("FAIL pulse cyc=%0d got sec_en=%b min_en=%b cnt_clr=%b, required cyc=%0d sec_en=%b min_en=%b cnt_clr=%b",
                   cyc, sec_en, min_en, cnt_clr, e.cyc, e.s, e.m, e.c);
      end
    end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
      n_total++;
      e = evq.pop_front();
      $display("FAIL missing_pulse cyc=%0d got none, required sec_en=%b min_en=%b cnt_clr=%b",
               e.cyc, e.s, e.m, e.c);
    end
    while (prq.size() > 0 && prq[0].cyc <= cyc) begin
      p = prq.pop_front();
      n_total++;
      if (p.cyc == cyc && p.run == running && p.lap == lap_active &&
          p.ds == disp_sec && p.dm == disp_min)
        n_pass++;
      else
        $display("FAIL probe cyc=%0d got run=%b lap=%b disp=%0d:%0d, required cyc=%0d run=%b lap=%b disp=%0d:%0d",
                 cyc, running, lap_active, disp_min, disp_sec, p.cyc, p.run, p.lap, p.dm, p.ds);
    end
  end

  initial begin
    // Reset held for three edges
    exp_clr(1); exp_clr(2); exp_clr(3);
    probe(2, 0, 0, 0, 0);
    at(3); rst = 1'b0;
    probe(4, 0, 0, 0, 0);

    // Preload counters near 59:59 to reach carry and rollover quickly
    at(5); ld = 1'b1; ld_sec = 6'd57; ld_min = 6'd59;
    at(6); ld = 1'b0;
    probe(7, 0, 0, 57, 59);

    // Basic run: running two edges after the press, ticks every 4 cycles
    at(8); start_stop_btn = 1'b1;
    probe(9, 0, 0, 57, 59);
    probe(10, 1, 0, 57, 59);
    exp_tick(14, 1'b0);
    exp_tick(18, 1'b0);
    exp_tick(22, 1'b1);
    for (int c = 26; c <= 50; c += 4) exp_tick(c, 1'b0);
    probe(24, 1, 0, 0, 0);
    at(10); start_stop_btn = 1'b0;

    // Lap at 00:07 freezes the display while counting continues
    at(51); lap_btn = 1'b1;
    probe(52, 1, 0, 7, 0);
    probe(53, 1, 1, 7, 0);
    exp_tick(54, 1'b0); exp_tick(58, 1'b0);
    probe(60, 1, 1, 7, 0);
    exp_tick(62, 1'b0);
    at(53); lap_btn = 1'b0;

    // Second lap edge releases the freeze
    at(63); lap_btn = 1'b1;
    probe(64, 1, 1, 7, 0);
    probe(65, 1, 0, 10, 0);
    exp_tick(66, 1'b0); exp_tick(70, 1'b0);
    at(65); lap_btn = 1'b0;

    // Enter LAP again, then start goes to PAUSE with live display
    at(67); lap_btn = 1'b1;
    probe(69, 1, 1, 11, 0);
    probe(72, 1, 1, 11, 0);
    probe(73, 0, 0, 12, 0);
    at(69); lap_btn = 1'b0;
    at(71); start_stop_btn = 1'b1;
    at(73); start_stop_btn = 1'b0;

    // Resume with one prescaler count left
    at(75); start_stop_btn = 1'b1;
    probe(77, 1, 0, 12, 0);
    exp_tick(78, 1'b0); exp_tick(82, 1'b0);
    at(77); start_stop_btn = 1'b0;

    // Pause after two prescaler counts, hold, resume: tick two cycles later
    at(82); start_stop_btn = 1'b1;
    probe(84, 0, 0, 14, 0);
    probe(90, 0, 0, 14, 0);
    at(84); start_stop_btn = 1'b0;
    at(93); start_stop_btn = 1'b1;
    probe(95, 1, 0, 14, 0);
    exp_tick(97, 1'b0);
    exp_tick(101, 1'b0);
    at(95); start_stop_btn = 1'b0;

    // Pause edge on the tick cycle: tick still issued
    at(99); start_stop_btn = 1'b1;
    probe(101, 0, 0, 15, 0);
    at(101); start_stop_btn = 1'b0;

    at(103); start_stop_btn = 1'b1;
    exp_tick(109, 1'b0);
    at(105); start_stop_btn = 1'b0;

    // Clear while running is ignored
    at(106); clear_btn = 1'b1;
    probe(108, 1, 0, 16, 0);
    at(108); clear_btn = 1'b0;

    // Start+lap together in RUN: PAUSE only
    at(110); start_stop_btn = 1'b1; lap_btn = 1'b1;
    probe(112, 0, 0, 17, 0);
    at(112); start_stop_btn = 1'b0; lap_btn = 1'b0;

    // Clear+start together in PAUSE: IDLE with clear, prescaler zeroed
    at(114); clear_btn = 1'b1; start_stop_btn = 1'b1;
    exp_clr(116);
    probe(116, 0, 0, 17, 0);
    probe(117, 0, 0, 0, 0);
    at(116); clear_btn = 1'b0; start_stop_btn = 1'b0;

    // Full second from a zeroed prescaler
    at(118); start_stop_btn = 1'b1;
    probe(120, 1, 0, 0, 0);
    exp_tick(124, 1'b0);
    at(120); start_stop_btn = 1'b0;

    // Reset mid-count suppresses the pending tick
    at(125); rst = 1'b1;
    exp_clr(126); exp_clr(127);
    probe(126, 0, 0, 1, 0);
    at(127); rst = 1'b0;
    probe(129, 0, 0, 0, 0);

    at(140);
    n_total++;
    if (evq.size() == 0 && prq.size() == 0)
      n_pass++;
    else
      $display("FAIL leftover got events=%0d probes=%0d, required 0/0", evq.size(), prq.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish by cyc=%0d, required finish by 140", cyc);
    $fatal(1, "watchdog");
  end

endmodule
